// File: rtl/bf16_divider_if.sv
// Handshake and result bundle for the BF16 divider.
interface bf16_divider_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] A;
  logic [15:0] B;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        zero;
  logic        underflow;
  logic        overflow;
  logic        qNaN;
  logic        sNaN;
  logic        positive_inf;
  logic        negative_inf;

  modport master (
    output in_valid, A, B, out_ready,
    input  in_ready, out_valid, result,
    input  zero, underflow, overflow, qNaN, sNaN, positive_inf, negative_inf
  );

  modport slave (
    input  in_valid, A, B, out_ready,
    output in_ready, out_valid, result,
    output zero, underflow, overflow, qNaN, sNaN, positive_inf, negative_inf
  );
endinterface

// File: rtl/bf16_divider.sv
// Sequential BF16 divider: A / B via a 10-step radix-2 restoring mantissa
// loop, round-to-nearest-even, and the multiply-add flag set.
module bf16_divider (
  input  logic          clk,
  input  logic          rst,
  bf16_divider_if.slave io
);

  typedef enum logic [1:0] {IDLE, CALC, ROUND, DONE} state_t;

  typedef struct packed {
    logic [15:0] res;
    logic        zero;
    logic        qnan;
    logic        snan;
    logic        pinf;
    logic        ninf;
  } special_t;

  state_t             state;
  logic [15:0]        a_r;
  logic [15:0]        b_r;
  logic [8:0]         rem;
  logic [7:0]         dvs;
  logic [9:0]         q;
  logic signed [9:0]  e;
  logic [3:0]         cnt;
  logic               special_r;

  logic               in_special;
  logic               ge;
  logic [7:0]         rem_sub;
  special_t           sp;
  logic               sign;
  logic [8:0]         mant9;
  logic               guard;
  logic               sticky;
  logic               carry;
  logic signed [9:0]  e_adj;

  // Result of a division whose operands hit a zero/inf/NaN class.
  function automatic special_t classify(input logic [15:0] a, input logic [15:0] b);
    special_t s;
    logic     a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_snan, b_snan, sg;
    a_zero = (a[14:7] == 8'h00);
    b_zero = (b[14:7] == 8'h00);
    a_inf  = (a[14:7] == 8'hFF) && (a[6:0] == 7'h00);
    b_inf  = (b[14:7] == 8'hFF) && (b[6:0] == 7'h00);
    a_nan  = (a[14:7] == 8'hFF) && (a[6:0] != 7'h00);
    b_nan  = (b[14:7] == 8'hFF) && (b[6:0] != 7'h00);
    a_snan = a_nan && !a[6];
    b_snan = b_nan && !b[6];
    sg     = a[15] ^ b[15];
    s      = '0;
    if (a_nan || b_nan) begin
      s.res  = 16'h7FC0;
      s.qnan = 1'b1;
      s.snan = a_snan || b_snan;
    end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
      s.res  = 16'h7FC0;
      s.qnan = 1'b1;
    end else if (a_inf || b_zero) begin
      s.res  = {sg, 8'hFF, 7'h00};
      s.pinf = !sg;
      s.ninf = sg;
    end else begin
      // remaining cases: zero dividend or infinite divisor
      s.res  = {sg, 15'h0000};
      s.zero = 1'b1;
    end
    return s;
  endfunction

  // Any operand with exponent 0 or FF bypasses the mantissa loop.
  assign in_special = (io.A[14:7] == 8'h00) || (io.A[14:7] == 8'hFF) ||
                      (io.B[14:7] == 8'h00) || (io.B[14:7] == 8'hFF);

  assign io.in_ready = (state == IDLE) && !rst;

  assign sp   = classify(a_r, b_r);
  assign sign = a_r[15] ^ b_r[15];

  // One restoring step: trial subtract of the divisor from the partial remainder.
  always_comb begin
    ge      = (rem >= {1'b0, dvs});
    rem_sub = rem[7:0];
    if (ge) rem_sub = 8'(rem - {1'b0, dvs});
  end

  // Normalise the quotient, pick guard/sticky and round to nearest even.
  always_comb begin
    mant9  = '0;
    guard  = 1'b0;
    sticky = 1'b0;
    e_adj  = e;
    if (q[9]) begin
      mant9  = {1'b0, q[9:2]};
      guard  = q[1];
      sticky = q[0] | (rem != 9'd0);
    end else begin
      mant9  = {1'b0, q[8:1]};
      guard  = q[0];
      sticky = (rem != 9'd0);
      e_adj  = e - 10'sd1;
    end
    if (guard && (sticky || mant9[0])) mant9 = mant9 + 9'd1;
    carry = (mant9[8:7] == 2'b10);
    if (carry) begin
      mant9 = 9'h080;
      e_adj = e_adj + 10'sd1;
    end
  end

  // Control FSM, iteration datapath and registered result/flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      a_r             <= '0;
      b_r             <= '0;
      rem             <= '0;
      dvs             <= '0;
      q               <= '0;
      e               <= '0;
      cnt             <= '0;
      special_r       <= 1'b0;
      io.out_valid    <= 1'b0;
      io.result       <= '0;
      io.zero         <= 1'b0;
      io.underflow    <= 1'b0;
      io.overflow     <= 1'b0;
      io.qNaN         <= 1'b0;
      io.sNaN         <= 1'b0;
      io.positive_inf <= 1'b0;
      io.negative_inf <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (io.in_valid) begin
            a_r       <= io.A;
            b_r       <= io.B;
            rem       <= {2'b01, io.A[6:0]};
            dvs       <= {1'b1, io.B[6:0]};
            q         <= '0;
            cnt       <= '0;
            e         <= $signed({2'b00, io.A[14:7]}) - $signed({2'b00, io.B[14:7]}) + 10'sd127;
            special_r <= in_special;
            // specials take ROUND as their single pass-through cycle
            state     <= in_special ? ROUND : CALC;
          end
        end
        CALC: begin
          q   <= {q[8:0], ge};
          rem <= {rem_sub, 1'b0};
          cnt <= cnt + 4'd1;
          if (cnt == 4'd9) state <= ROUND;
        end
        ROUND: begin
          io.underflow <= 1'b0;
          io.overflow  <= 1'b0;
          if (special_r) begin
            io.result       <= sp.res;
            io.zero         <= sp.zero;
            io.qNaN         <= sp.qnan;
            io.sNaN         <= sp.snan;
            io.positive_inf <= sp.pinf;
            io.negative_inf <= sp.ninf;
          end else begin
            io.qNaN <= 1'b0;
            io.sNaN <= 1'b0;
            if (e_adj >= 10'sd255) begin
              io.result       <= {sign, 8'hFF, 7'h00};
              io.overflow     <= 1'b1;
              io.zero         <= 1'b0;
              io.positive_inf <= !sign;
              io.negative_inf <= sign;
            end else if (e_adj <= 10'sd0) begin
              io.result       <= {sign, 15'h0000};
              io.underflow    <= 1'b1;
              io.zero         <= 1'b1;
              io.positive_inf <= 1'b0;
              io.negative_inf <= 1'b0;
            end else begin
              io.result       <= {sign, e_adj[7:0], mant9[6:0]};
              io.zero         <= 1'b0;
              io.positive_inf <= 1'b0;
              io.negative_inf <= 1'b0;
            end
          end
          io.out_valid <= 1'b1;
          state        <= DONE;
        end
        DONE: begin
          if (io.out_ready) begin
            io.out_valid <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
